aexm_regf_mp: RTL

Parametrised multi-port general-purpose register file for the aexm core. It is the next generation of the single-configuration register file and adds the following:
- configurable data width, register count and read-port count;
- a sign-extending load sizer;
- a load-pending scoreboard that reports hazards to the decode stage;
- a sequential zero-initialisation sweep after reset.

It sits between decode (read ports), the data-cache interface (load return, store data) and writeback.

---
 rtl/aexm_pkg.sv | 37 +++
 rtl/aexm_ldsizer.sv | 51 +++++
 rtl/aexm_regf_mp.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/aexm_pkg.sv
// Shared codes for the aexm register file: writeback source select, store
// size encoding and the initialisation/run state of the register file.
package aexm_pkg;

    // Writeback source select
    localparam logic [1:0] WRM_RES  = 2'd0;
    localparam logic [1:0] WRM_LNK  = 2'd1;
    localparam logic [1:0] WRM_LD   = 2'd2;
    localparam logic [1:0] WRM_NONE = 2'd3;

    // Store size, log2 of the byte count
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } regf_state_e;

    // Byte-lane wrap mask for store replication: lane j of the output takes
    // source lane (j & mask). Because the mask is 2^n-1, a store wider than
    // the datapath naturally degenerates to an identity copy.
    function automatic logic [2:0] lane_wrap_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            SZ_B:    m = 3'd0;
            SZ_H:    m = 3'd1;
            SZ_W:    m = 3'd3;
            SZ_D:    m = 3'd7;
            default: m = 3'd7;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/aexm_ldsizer.sv
// Load sizer: extracts a contiguous, naturally aligned run of byte lanes from
// the raw cache word, right-justifies it and zero/sign-extends it. Any lane
// select that is not such a run yields zero. Purely combinational so it can
// also sit on the cache fill path.
module aexm_ldsizer #(
    parameter int DW = 32
) (
    input  logic [DW/8-1:0] sel,
    input  logic            sext,
    input  logic [DW-1:0]   datai,
    output logic [DW-1:0]   dato
);

    localparam int NB = DW / 8;
    localparam int LG = $clog2(NB);
    localparam logic [NB-1:0] LANE_ONES = {NB{1'b1}};
    localparam logic [DW-1:0] DATA_ONES = {DW{1'b1}};
    localparam logic [DW-1:0] DATA_ONE  = {{(DW-1){1'b0}}, 1'b1};

    // True when sel is exactly s lanes starting at lane k, with k aligned to s
    function automatic logic lane_match(input int s, input int k,
                                        input logic [NB-1:0] sl);
        return (s <= NB) && ((k % s) == 0) && ((k + s) <= NB) &&
               (sl == ((LANE_ONES >> (NB - s)) << k));
    endfunction

    // Value of an s-lane field at lane k, right-justified and extended
    function automatic logic [DW-1:0] lane_value(input int s, input int k,
                                                 input logic [DW-1:0] d,
                                                 input logic sx);
        logic [DW-1:0] sh;
        logic [DW-1:0] vm;
        logic          sb;
        sh = d >> (k * 8);
        vm = DATA_ONES >> (DW - s * 8);
        sb = |(sh & (DATA_ONE << (s * 8 - 1)));
        return (sh & vm) | ((sx && sb) ? ~vm : '0);
    endfunction

    // At most one candidate field matches, so the results can simply be OR-ed
    always_comb begin
        dato = '0;
        for (int lg = 0; lg <= LG; lg++) begin
            for (int k = 0; k < NB; k++) begin
                dato = dato | ({DW{lane_match(1 << lg, k, sel)}} &
                               lane_value(1 << lg, k, datai, sext));
            end
        end
    end

endmodule

// File: rtl/aexm_regf_mp.sv
// Multi-port general-purpose register file for the aexm core. Combinational
// read ports with same-cycle writeback bypass, a load-pending scoreboard,
// a replicating store-data register and a zero-fill sweep after reset.
module aexm_regf_mp
    import aexm_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              gclk,
    input  logic              grst,
    input  logic              x_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic [AW-1:0]     wr_addr,
    input  logic [1:0]        wr_mux,
    input  logic [DW-1:0]     wr_result,
    input  logic [DW-1:0]     wr_link,
    input  logic              ld_issue,
    input  logic [AW-1:0]     ld_dst,
    input  logic [DW/8-1:0]   ld_sel,
    input  logic              ld_sext,
    input  logic [DW-1:0]     dcache_datai,
    input  logic [AW-1:0]     st_addr,
    input  logic [1:0]        st_size,
    output logic [DW-1:0]     st_data,
    output logic              init_busy
);

    localparam int NB = DW / 8;
    localparam logic [NREG-1:0] REG_ONE = {{(NREG-1){1'b0}}, 1'b1};

    regf_state_e     state_r;
    logic [AW-1:0]   cnt_r;
    logic            init_busy_r;
    logic [NREG-1:0] busy_r;
    logic [DW-1:0]   st_data_r;

    // One copy of the register array per read port, all written identically
    logic [DW-1:0]   mem_r [NRD][NREG];

    logic            run_s;
    logic            wr_act_s;
    logic [DW-1:0]   wdat_s;
    logic [DW-1:0]   ld_data_s;
    logic            mem_we_s;
    logic [AW-1:0]   mem_wa_s;
    logic [DW-1:0]   mem_wd_s;
    logic [NREG-1:0] set_vec_s;
    logic [NREG-1:0] clr_vec_s;
    logic [NREG-1:0] busy_nx_s;
    logic [DW-1:0]   st_src_s;
    logic [2:0]      st_lm_s;
    logic [DW-1:0]   st_rep_s;

    aexm_ldsizer #(
        .DW(DW)
    ) u_ldsizer (
        .sel   (ld_sel),
        .sext  (ld_sext),
        .datai (dcache_datai),
        .dato  (ld_data_s)
    );

    assign run_s    = (state_r == ST_RUN);
    assign wr_act_s = run_s && x_en && (wr_mux != WRM_NONE) && (wr_addr != '0);

    // Writeback data source select
    always_comb begin
        wdat_s = '0;
        case (wr_mux)
            WRM_RES: wdat_s = wr_result;
            WRM_LNK: wdat_s = wr_link;
            WRM_LD:  wdat_s = ld_data_s;
            default: wdat_s = '0;
        endcase
    end

    // Array write port: the sweep owns it during INIT, writeback in RUN
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = '0;
        mem_wd_s = '0;
        if (!run_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = cnt_r;
            mem_wd_s = '0;
        end else begin
            mem_we_s = wr_act_s;
            mem_wa_s = wr_addr;
            mem_wd_s = wdat_s;
        end
    end

    // Register storage, no reset so it can map onto distributed RAM
    always_ff @(posedge gclk) begin
        for (int i = 0; i < NRD; i++) begin
            if (mem_we_s) begin
                mem_r[i][mem_wa_s] <= mem_wd_s;
            end
        end
    end

    // Read ports: zero register, same-cycle bypass, then the port's own copy
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!run_s || (rd_addr[i*AW +: AW] == '0)) begin
                rd_data[i*DW +: DW] = '0;
                rd_busy[i]          = 1'b0;
            end else if (wr_act_s && (wr_addr == rd_addr[i*AW +: AW])) begin
                rd_data[i*DW +: DW] = wdat_s;
                rd_busy[i]          = busy_r[rd_addr[i*AW +: AW]] && (wr_mux != WRM_LD);
            end else begin
                rd_data[i*DW +: DW] = mem_r[i][rd_addr[i*AW +: AW]];
                rd_busy[i]          = busy_r[rd_addr[i*AW +: AW]];
            end
        end
    end

    // Scoreboard next state: clear on load writeback, a new issue wins
    assign set_vec_s = (run_s && x_en && ld_issue && (ld_dst != '0)) ? (REG_ONE << ld_dst) : '0;
    assign clr_vec_s = (wr_act_s && (wr_mux == WRM_LD)) ? (REG_ONE << wr_addr) : '0;
    assign busy_nx_s = (busy_r & ~clr_vec_s) | set_vec_s;

    // Store source with forwarding from the write in flight
    always_comb begin
        st_src_s = '0;
        if (wr_act_s && (wr_addr == st_addr)) begin
            st_src_s = wdat_s;
        end else if (st_addr == '0) begin
            st_src_s = '0;
        end else begin
            st_src_s = mem_r[0][st_addr];
        end
    end

    // Replicate the low 2^st_size bytes across the whole store word
    always_comb begin
        st_lm_s  = lane_wrap_mask(st_size);
        st_rep_s = '0;
        for (int j = 0; j < NB; j++) begin
            st_rep_s[j*8 +: 8] = st_src_s[(j & int'(st_lm_s))*8 +: 8];
        end
    end

    // Control FSM: zero-fill sweep counter, then run
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            state_r     <= ST_INIT;
            cnt_r       <= '0;
            init_busy_r <= 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_r <= cnt_r + AW'(1);
                    if (cnt_r == AW'(NREG - 1)) begin
                        state_r     <= ST_RUN;
                        init_busy_r <= 1'b0;
                    end else begin
                        state_r     <= ST_INIT;
                        init_busy_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_r     <= ST_RUN;
                    cnt_r       <= cnt_r;
                    init_busy_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_INIT;
                    cnt_r       <= '0;
                    init_busy_r <= 1'b1;
                end
            endcase
        end
    end

    // Load-pending scoreboard, held clear outside RUN
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            busy_r <= '0;
        end else if (run_s) begin
            busy_r <= busy_nx_s;
        end else begin
            busy_r <= '0;
        end
    end

    // Store data register, advances with the pipeline in RUN only
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            st_data_r <= '0;
        end else if (run_s && x_en) begin
            st_data_r <= st_rep_s;
        end else begin
            st_data_r <= st_data_r;
        end
    end

    assign st_data   = st_data_r;
    assign init_busy = init_busy_r;

endmodule
